// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: frame qualifier, FWFT frame FIFO and statistics behind a 16x-oversampled UART receiver
// Ports:
//   clk, rst_n                    clock and synchronous active-low reset
//   rx_baud_tick                  16x baud strobe shared with the receiver
//   rx_ready, rx_data, rx_error   receiver handshake, data and stop-bit error
//   rx_en, rx_flush, clear_stats  store enable, FIFO flush pulse, statistics clear pulse
//   out_valid, out_data, out_err  head of FIFO (first-word fall-through), popped by out_ready
//   fifo_count, fifo_full         FIFO occupancy
//   overrun, err_count            sticky drop flag and stored-error count
//   glitch_count, busy            rejected short frames and receiver-busy indicator
module uart_rx_frame_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 3,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_baud_tick,
  input  logic                 rx_ready,
  input  logic [DATA_BITS-1:0] rx_data,
  input  logic                 rx_error,
  input  logic                 rx_en,
  input  logic                 rx_flush,
  input  logic                 clear_stats,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_err,
  input  logic                 out_ready,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 fifo_full,
  output logic                 overrun,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     glitch_count,
  output logic                 busy
);
  typedef enum logic [1:0] {SYNC, IDLE, BUSY, CAPTURE} state_t;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [11:0] MIN_TICKS = 12'(16 * (DATA_BITS + 1));
  state_t state;
  logic [11:0] tick_cnt;
  logic [DATA_BITS:0] cap;
  logic [DATA_BITS:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr, head;
  logic [FIFO_AW:0] rem;
  logic pop, cap_req, push, drop_full, glitch;
  assign pop = out_valid & out_ready;
  assign cap_req = (state == CAPTURE) & rx_en;
  assign push = cap_req & ~fifo_full & ~rx_flush;
  assign drop_full = cap_req & fifo_full & ~rx_flush;
  assign glitch = (state == BUSY) & rx_ready & (tick_cnt < MIN_TICKS);
  assign fifo_full = fifo_count == (FIFO_AW+1)'(DEPTH);
  assign busy = state == BUSY;
  // The output stage looks past this cycle's pop but not this cycle's push,
  // so a new frame reaches out_valid one cycle after it lands in the FIFO.
  assign rem = fifo_count - {{FIFO_AW{1'b0}}, pop};
  assign head = rptr + {{(FIFO_AW-1){1'b0}}, pop};
  always_ff @(posedge clk)
    if (push) mem[wptr] <= cap;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SYNC;
      tick_cnt <= '0;
      cap <= '0;
      wptr <= '0;
      rptr <= '0;
      fifo_count <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_err <= 1'b0;
      overrun <= 1'b0;
      err_count <= '0;
      glitch_count <= '0;
    end else begin
      case (state)
        SYNC: if (rx_ready) state <= IDLE;
        IDLE: begin
          tick_cnt <= '0;
          if (!rx_ready) state <= BUSY;
        end
        BUSY: begin
          if (rx_ready) begin
            state <= glitch ? IDLE : CAPTURE;
            cap <= {rx_error, rx_data};
          end else if (rx_baud_tick && tick_cnt != '1) tick_cnt <= tick_cnt + 12'd1;
        end
        default: state <= IDLE;
      endcase
      if (rx_flush) begin
        wptr <= '0;
        rptr <= '0;
        fifo_count <= '0;
        out_valid <= 1'b0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        fifo_count <= rem + {{FIFO_AW{1'b0}}, push};
        out_valid <= rem != '0;
        if (rem != '0) {out_err, out_data} <= mem[head];
      end
      overrun <= clear_stats ? 1'b0 : overrun | drop_full;
      err_count <= clear_stats ? '0 : err_count + CNT_W'(push & cap[DATA_BITS] & (err_count != '1));
      glitch_count <= clear_stats ? '0 : glitch_count + CNT_W'(glitch & (glitch_count != '1));
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;
  logic clk = 1'b0;
  logic rst_n, rx_baud_tick, rx_ready, rx_error, rx_en, rx_flush, clear_stats, out_ready;
  logic [7:0] rx_data, out_data;
  logic out_valid, out_err, fifo_full, overrun, busy;
  logic [3:0] fifo_count, tcnt;
  logic [7:0] err_count, glitch_count;
  int total = 0;
  int fails = 0;
  uart_rx_frame_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_baud_tick(rx_baud_tick), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_error(rx_error), .rx_en(rx_en), .rx_flush(rx_flush),
    .clear_stats(clear_stats), .out_valid(out_valid), .out_data(out_data),
    .out_err(out_err), .out_ready(out_ready), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .overrun(overrun), .err_count(err_count),
    .glitch_count(glitch_count), .busy(busy)
  );
  always #5 clk = ~clk;
  initial tcnt = 4'd0;
  always @(negedge clk) begin
    tcnt = tcnt + 4'd1;
    rx_baud_tick = tcnt == 4'd0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic frame(input logic [7:0] d, input logic e, input int nt);
    @(negedge clk) rx_ready = 1'b0;
    repeat (nt * 16) @(negedge clk);
    rx_data = d;
    rx_error = e;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask
  task automatic pop1();
    out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; rx_error = 1'b0; rx_en = 1'b1;
    rx_flush = 1'b0; clear_stats = 1'b0; out_ready = 1'b0; rx_baud_tick = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stats", {err_count, glitch_count}, 0);
    rst_n = 1'b1;
    @(negedge clk) rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t1_count", fifo_count, 0);
    chk("t1_glitch", glitch_count, 0);
    chk("t1_busy", busy, 0);
    rx_ready = 1'b0;
    repeat (40) @(negedge clk);
    chk("t2_busy", busy, 1);
    repeat (152 * 16 - 40) @(negedge clk);
    rx_data = 8'hA5;
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t2_capture_notbusy", busy, 0);
    @(negedge clk);
    chk("t2_lat_valid", out_valid, 0);
    chk("t2_lat_count", fifo_count, 1);
    @(negedge clk);
    chk("t2_valid", out_valid, 1);
    chk("t2_data", out_data, 8'hA5);
    chk("t2_err", out_err, 0);
    chk("t2_count", fifo_count, 1);
    pop1();
    chk("t2_pop_count", fifo_count, 0);
    chk("t2_pop_valid", out_valid, 0);
    frame(8'h11, 1'b0, 8);
    chk("t3_count", fifo_count, 0);
    chk("t3_valid", out_valid, 0);
    chk("t3_glitch", glitch_count, 1);
    chk("t3_busy", busy, 0);
    for (int i = 0; i < 8; i++) frame(8'(i), 1'b0, 150);
    frame(8'h3C, 1'b0, 150);
    chk("t4_full", fifo_full, 1);
    chk("t4_overrun", overrun, 1);
    chk("t4_count", fifo_count, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_drain_valid%0d", i), out_valid, 1);
      chk($sformatf("t4_drain_data%0d", i), out_data, i);
      pop1();
    end
    chk("t4_empty_count", fifo_count, 0);
    chk("t4_empty_valid", out_valid, 0);
    chk("t4_hold_data", out_data, 8'h07);
    frame(8'h00, 1'b1, 150);
    rx_error = 1'b0;
    chk("t5_err", out_err, 1);
    chk("t5_data", out_data, 8'h00);
    chk("t5_errcnt", err_count, 1);
    pop1();
    clear_stats = 1'b1;
    @(negedge clk) clear_stats = 1'b0;
    chk("t5_clr_err", err_count, 0);
    chk("t5_clr_overrun", overrun, 0);
    chk("t5_clr_glitch", glitch_count, 0);
    rx_en = 1'b0;
    frame(8'h55, 1'b0, 150);
    rx_en = 1'b1;
    chk("t6_disabled_count", fifo_count, 0);
    chk("t6_disabled_overrun", overrun, 0);
    frame(8'h61, 1'b0, 150);
    frame(8'h62, 1'b0, 150);
    frame(8'h63, 1'b0, 150);
    chk("t6_three", fifo_count, 3);
    @(negedge clk) rx_ready = 1'b0;
    repeat (150 * 16) @(negedge clk);
    rx_data = 8'h64;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rx_flush = 1'b0;
    out_ready = 1'b0;
    chk("t6_flush_count", fifo_count, 0);
    chk("t6_flush_valid", out_valid, 0);
    chk("t6_flush_overrun", overrun, 0);
    repeat (2) @(negedge clk);
    chk("t6_flush_nopush", fifo_count, 0);
    rx_ready = 1'b0;
    repeat (50 * 16) @(negedge clk);
    chk("t6_midbusy", busy, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk) rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_glitch", glitch_count, 0);
    chk("t6_rst_busy", busy, 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
